// File: rtl/ddr_arbiter_if.sv
// Port bundle for the two-requester DDR burst arbiter: two requester ports
// plus the shared Avalon-MM master port toward the DDR controller.
interface ddr_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // Handshake: a command (rd) or write beat (wr) transfers on a rising clock
  // edge where it is high and waitReq is low; rd/wr, addr, burstLength, mask
  // and din must hold until then. Read beats have no back-pressure: valid
  // marks a beat on dout for exactly one cycle.
  logic                   io_in0_rd;
  logic                   io_in0_wr;
  logic [ADDR_WIDTH-1:0]  io_in0_addr;
  logic [BURST_WIDTH-1:0] io_in0_burstLength;
  logic [MASK_WIDTH-1:0]  io_in0_mask;
  logic [DATA_WIDTH-1:0]  io_in0_din;
  logic                   io_in0_waitReq;
  logic                   io_in0_valid;
  logic [DATA_WIDTH-1:0]  io_in0_dout;
  logic                   io_in0_burstDone;

  logic                   io_in1_rd;
  logic                   io_in1_wr;
  logic [ADDR_WIDTH-1:0]  io_in1_addr;
  logic [BURST_WIDTH-1:0] io_in1_burstLength;
  logic [MASK_WIDTH-1:0]  io_in1_mask;
  logic [DATA_WIDTH-1:0]  io_in1_din;
  logic                   io_in1_waitReq;
  logic                   io_in1_valid;
  logic [DATA_WIDTH-1:0]  io_in1_dout;
  logic                   io_in1_burstDone;

  logic                   io_ddr_rd;
  logic                   io_ddr_wr;
  logic [ADDR_WIDTH-1:0]  io_ddr_addr;
  logic [BURST_WIDTH-1:0] io_ddr_burstLength;
  logic [MASK_WIDTH-1:0]  io_ddr_mask;
  logic [DATA_WIDTH-1:0]  io_ddr_din;
  logic [DATA_WIDTH-1:0]  io_ddr_dout;
  logic                   io_ddr_waitReq;
  logic                   io_ddr_valid;

  modport slave (
    input  io_in0_rd, io_in0_wr, io_in0_addr, io_in0_burstLength, io_in0_mask, io_in0_din,
    output io_in0_waitReq, io_in0_valid, io_in0_dout, io_in0_burstDone,
    input  io_in1_rd, io_in1_wr, io_in1_addr, io_in1_burstLength, io_in1_mask, io_in1_din,
    output io_in1_waitReq, io_in1_valid, io_in1_dout, io_in1_burstDone,
    output io_ddr_rd, io_ddr_wr, io_ddr_addr, io_ddr_burstLength, io_ddr_mask, io_ddr_din,
    input  io_ddr_dout, io_ddr_waitReq, io_ddr_valid
  );

  modport master (
    output io_in0_rd, io_in0_wr, io_in0_addr, io_in0_burstLength, io_in0_mask, io_in0_din,
    input  io_in0_waitReq, io_in0_valid, io_in0_dout, io_in0_burstDone,
    output io_in1_rd, io_in1_wr, io_in1_addr, io_in1_burstLength, io_in1_mask, io_in1_din,
    input  io_in1_waitReq, io_in1_valid, io_in1_dout, io_in1_burstDone,
    input  io_ddr_rd, io_ddr_wr, io_ddr_addr, io_ddr_burstLength, io_ddr_mask, io_ddr_din,
    output io_ddr_dout, io_ddr_waitReq, io_ddr_valid
  );
endinterface

// File: rtl/ddr_arbiter.sv
// Round-robin whole-burst arbiter sharing one DDR Avalon-MM master between
// the tile-fetch port (0) and the frame-buffer writer port (1).
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  ddr_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_CMD  = 2'd1,
    READ_DATA = 2'd2,
    WRITE     = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   grant, grant_nxt;
  logic                   prio, prio_nxt;
  logic [BURST_WIDTH-1:0] beats, beats_nxt;

  logic                   req0, req1, win;
  logic                   g_rd, g_wr;
  logic [ADDR_WIDTH-1:0]  g_addr;
  logic [BURST_WIDTH-1:0] g_len;
  logic [MASK_WIDTH-1:0]  g_mask;
  logic [DATA_WIDTH-1:0]  g_din;
  logic                   g_wait, rd_valid, beat_done, ddr_rd, ddr_wr;

  assign req0 = bus.io_in0_rd | bus.io_in0_wr;
  assign req1 = bus.io_in1_rd | bus.io_in1_wr;
  assign win  = (req0 & req1) ? prio : req1;

  always_comb begin : granted_mux
    if (grant) begin
      g_rd   = bus.io_in1_rd;
      g_wr   = bus.io_in1_wr;
      g_addr = bus.io_in1_addr;
      g_len  = bus.io_in1_burstLength;
      g_mask = bus.io_in1_mask;
      g_din  = bus.io_in1_din;
    end else begin
      g_rd   = bus.io_in0_rd;
      g_wr   = bus.io_in0_wr;
      g_addr = bus.io_in0_addr;
      g_len  = bus.io_in0_burstLength;
      g_mask = bus.io_in0_mask;
      g_din  = bus.io_in0_din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= 1'b0;
      prio  <= 1'b0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      prio  <= prio_nxt;
      beats <= beats_nxt;
    end
  end

  // A burst length of 0 loads 0 and wraps through all 2^BURST_WIDTH beats.
  always_comb begin : fsm
    state_nxt = state;
    grant_nxt = grant;
    prio_nxt  = prio;
    beats_nxt = beats;
    g_wait    = 1'b1;
    rd_valid  = 1'b0;
    beat_done = 1'b0;
    ddr_rd    = 1'b0;
    ddr_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_nxt = win;
          beats_nxt = win ? bus.io_in1_burstLength : bus.io_in0_burstLength;
          state_nxt = (win ? bus.io_in1_rd : bus.io_in0_rd) ? READ_CMD : WRITE;
        end
      end
      READ_CMD: begin
        ddr_rd = g_rd;
        g_wait = bus.io_ddr_waitReq;
        if (!bus.io_ddr_waitReq) state_nxt = READ_DATA;
      end
      READ_DATA: begin
        if (bus.io_ddr_valid) begin
          rd_valid  = 1'b1;
          beats_nxt = beats - ONE;
          beat_done = (beats == ONE);
        end
      end
      WRITE: begin
        ddr_wr = g_wr;
        g_wait = bus.io_ddr_waitReq;
        if (g_wr && !bus.io_ddr_waitReq) begin
          beats_nxt = beats - ONE;
          beat_done = (beats == ONE);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (beat_done) begin
      state_nxt = IDLE;
      prio_nxt  = ~grant;
    end
  end

  assign bus.io_ddr_rd          = ddr_rd;
  assign bus.io_ddr_wr          = ddr_wr;
  assign bus.io_ddr_addr        = (state != IDLE) ? g_addr : '0;
  assign bus.io_ddr_burstLength = (state != IDLE) ? g_len  : '0;
  assign bus.io_ddr_mask        = (state != IDLE) ? g_mask : '0;
  assign bus.io_ddr_din         = (state != IDLE) ? g_din  : '0;

  assign bus.io_in0_waitReq   = grant ? 1'b1 : g_wait;
  assign bus.io_in1_waitReq   = grant ? g_wait : 1'b1;
  assign bus.io_in0_valid     = rd_valid & ~grant;
  assign bus.io_in1_valid     = rd_valid & grant;
  assign bus.io_in0_burstDone = beat_done & ~grant;
  assign bus.io_in1_burstDone = beat_done & grant;
  assign bus.io_in0_dout      = bus.io_ddr_dout;
  assign bus.io_in1_dout      = bus.io_ddr_dout;

  assign dbg_state = state;
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed plus randomized bench for ddr_arbiter, checked against a
// transaction-level round-robin model with a read-data scoreboard.
module tb_ddr_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int MW = DW / 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] dbg_state;

  ddr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  ddr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  bit prio_m = 1'b0;               // which port wins the next tie
  logic [DW-1:0] exp_q[$];         // read beats expected at the owning port

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic p_wait(input bit p);
    return p ? bus.io_in1_waitReq : bus.io_in0_waitReq;
  endfunction
  function automatic logic p_valid(input bit p);
    return p ? bus.io_in1_valid : bus.io_in0_valid;
  endfunction
  function automatic logic p_done(input bit p);
    return p ? bus.io_in1_burstDone : bus.io_in0_burstDone;
  endfunction
  function automatic logic [DW-1:0] p_dout(input bit p);
    return p ? bus.io_in1_dout : bus.io_in0_dout;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_port(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] l, input logic [MW-1:0] m, input logic [DW-1:0] d);
    if (p) begin
      bus.io_in1_rd = rd; bus.io_in1_wr = wr; bus.io_in1_addr = a;
      bus.io_in1_burstLength = l; bus.io_in1_mask = m; bus.io_in1_din = d;
    end else begin
      bus.io_in0_rd = rd; bus.io_in0_wr = wr; bus.io_in0_addr = a;
      bus.io_in0_burstLength = l; bus.io_in0_mask = m; bus.io_in0_din = d;
    end
  endtask

  task automatic set_req(input bit p, input bit rd, input bit wr);
    if (p) begin bus.io_in1_rd = rd; bus.io_in1_wr = wr; end
    else begin bus.io_in0_rd = rd; bus.io_in0_wr = wr; end
  endtask

  task automatic set_wdata(input bit p, input logic [MW-1:0] m, input logic [DW-1:0] d);
    if (p) begin bus.io_in1_mask = m; bus.io_in1_din = d; end
    else begin bus.io_in0_mask = m; bus.io_in0_din = d; end
  endtask

  task automatic clear_reqs();
    set_req(1'b0, 1'b0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0);
  endtask

  // Every output at its idle / reset value.
  task automatic check_quiet(input string tag);
    check({tag, "_state"}, dbg_state, 2'd0);
    check({tag, "_ddr_rdwr"}, {bus.io_ddr_rd, bus.io_ddr_wr}, 2'b00);
    check({tag, "_ddr_addr"}, bus.io_ddr_addr, 0);
    check({tag, "_ddr_len"}, bus.io_ddr_burstLength, 0);
    check({tag, "_ddr_mask_din"}, {bus.io_ddr_mask, bus.io_ddr_din[DW-MW-1:0]}, 0);
    check({tag, "_waitreq"}, {bus.io_in0_waitReq, bus.io_in1_waitReq}, 2'b11);
    check({tag, "_valid_done"}, {bus.io_in0_valid, bus.io_in1_valid,
                                 bus.io_in0_burstDone, bus.io_in1_burstDone}, 4'b0000);
  endtask

  // One IDLE cycle with random (stray) DDR activity.
  task automatic idle_check(input string tag);
    bus.io_ddr_valid   = 1'($urandom_range(0, 1));
    bus.io_ddr_waitReq = 1'($urandom_range(0, 1));
    bus.io_ddr_dout    = {$urandom, $urandom};
    @(negedge clock);
    check_quiet(tag);
    next_cycle();
  endtask

  // Starts in an IDLE cycle; returns in the IDLE cycle after the last beat.
  task automatic do_burst(input bit r0, input bit rd0, input logic [BW-1:0] l0,
                          input bit r1, input bit rd1, input logic [BW-1:0] l1,
                          input logic [AW-1:0] fix_addr, input bit use_pat, input logic [31:0] wpat);
    bit w, loser, wrd, wq;
    int nbeats, cyc_i, b;
    logic [AW-1:0] a0, a1, wa;
    logic [BW-1:0] wl;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    w = (r0 && r1) ? prio_m : r1;
    loser = ~w;
    a0 = $urandom;
    a1 = $urandom;
    if (fix_addr != '0) begin
      if (w) a1 = fix_addr; else a0 = fix_addr;
    end
    wa = w ? a1 : a0;
    wl = w ? l1 : l0;
    wrd = w ? rd1 : rd0;
    nbeats = (wl == '0) ? (1 << BW) : int'(wl);
    m = MW'($urandom);
    d = {$urandom, $urandom};
    drive_port(1'b0, r0 & rd0, r0 & ~rd0, a0, l0, MW'($urandom), {$urandom, $urandom});
    drive_port(1'b1, r1 & rd1, r1 & ~rd1, a1, l1, MW'($urandom), {$urandom, $urandom});
    if (!wrd) set_wdata(w, m, d);
    idle_check("arb");
    cyc_i = 0;
    if (wrd) begin
      do begin
        wq = use_pat ? wpat[cyc_i] : ($urandom_range(0, 2) == 0);
        if (cyc_i >= 20) wq = 1'b0;
        bus.io_ddr_waitReq = wq;
        bus.io_ddr_valid   = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("rdcmd_rd", bus.io_ddr_rd, 1'b1);
        check("rdcmd_addr", bus.io_ddr_addr, wa);
        check("rdcmd_len", bus.io_ddr_burstLength, wl);
        check("rdcmd_wait", p_wait(w), wq);
        check("rdcmd_loser_wait", p_wait(loser), 1'b1);
        check("rdcmd_stray", {bus.io_in0_valid, bus.io_in1_valid}, 2'b00);
        next_cycle();
        cyc_i++;
      end while (wq);
      set_req(w, 1'b0, 1'b0);
      for (b = 1; b <= nbeats; b++) begin
        while (!use_pat && $urandom_range(0, 3) == 0) begin
          bus.io_ddr_valid = 1'b0;
          bus.io_ddr_dout  = {$urandom, $urandom};
          @(negedge clock);
          check("rdgap_valid", {p_valid(w), p_done(w)}, 2'b00);
          check("rdgap_wait", p_wait(w), 1'b1);
          next_cycle();
        end
        d = {$urandom, $urandom};
        exp_q.push_back(d);
        bus.io_ddr_valid   = 1'b1;
        bus.io_ddr_dout    = d;
        bus.io_ddr_waitReq = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("rd_ddr_rd", bus.io_ddr_rd, 1'b0);
        check("rd_valid", p_valid(w), 1'b1);
        check("rd_loser_valid", {p_valid(loser), p_done(loser)}, 2'b00);
        check("rd_done", p_done(w), b == nbeats);
        check("rd_dout", p_dout(w), exp_q.pop_front());
        next_cycle();
      end
    end else begin
      b = 0;
      while (b < nbeats) begin
        if (use_pat) wq = (cyc_i < 32) ? wpat[cyc_i] : 1'b0;
        else wq = ($urandom_range(0, 2) == 0) && (cyc_i < 4 * nbeats + 16);
        bus.io_ddr_waitReq = wq;
        bus.io_ddr_valid   = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("wr_ddr_wr", {bus.io_ddr_rd, bus.io_ddr_wr}, 2'b01);
        check("wr_addr", bus.io_ddr_addr, wa);
        check("wr_len", bus.io_ddr_burstLength, wl);
        check("wr_din", bus.io_ddr_din, d);
        check("wr_mask", bus.io_ddr_mask, m);
        check("wr_wait", p_wait(w), wq);
        check("wr_loser_wait", p_wait(loser), 1'b1);
        check("wr_stray_valid", {bus.io_in0_valid, bus.io_in1_valid}, 2'b00);
        check("wr_done", p_done(w), !wq && (b == nbeats - 1));
        check("wr_loser_done", p_done(loser), 1'b0);
        next_cycle();
        cyc_i++;
        if (!wq) begin
          b++;
          m = MW'($urandom);
          d = {$urandom, $urandom};
          set_wdata(w, m, d);
        end
      end
      set_req(w, 1'b0, 1'b0);
    end
    bus.io_ddr_valid = 1'b0;
    prio_m = loser;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit r0, r1;
    clear_reqs();
    drive_port(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.io_ddr_dout = '0;
    bus.io_ddr_waitReq = 1'b1;
    bus.io_ddr_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_quiet("por");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Contention from reset: port 0 writes, port 1 reads, both always requesting.
    repeat (4) do_burst(1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 8'd3, '0, 1'b0, '0);
    clear_reqs();
    idle_check("cont_end");

    // Single port-0 read, two command wait cycles.
    do_burst(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 32'h1000, 1'b1, 32'b011);
    clear_reqs();
    idle_check("rd0_end");

    // Port-1 write of 3 beats with DDR waitReq 1,0,1,0,0.
    do_burst(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3, '0, 1'b1, 32'b00101);
    clear_reqs();
    idle_check("wr1_end");

    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      do_burst(r0, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 8)),
               r1, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 8)), '0, 1'b0, '0);
      if ($urandom_range(0, 1) == 1) begin
        clear_reqs();
        idle_check("rand_gap");
      end
    end
    clear_reqs();
    idle_check("rand_end");

    // Burst length 0 means 256 beats.
    do_burst(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, '0, 1'b1, '0);
    clear_reqs();
    idle_check("zero_end");

    // Leave port 1 with priority, then abort a port-0 read with reset.
    do_burst(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 8'd0, '0, 1'b0, '0);
    clear_reqs();
    drive_port(1'b0, 1'b1, 1'b0, 32'h2000, 8'd8, '0, '0);
    idle_check("rst_arb");
    bus.io_ddr_waitReq = 1'b0;
    bus.io_ddr_valid = 1'b0;
    @(negedge clock);
    check("rst_cmd", bus.io_ddr_rd, 1'b1);
    next_cycle();
    set_req(1'b0, 1'b0, 1'b0);
    bus.io_ddr_valid = 1'b1;
    bus.io_ddr_dout = 64'h1111_2222_3333_4444;
    @(negedge clock);
    check("rst_beat1", bus.io_in0_valid, 1'b1);
    next_cycle();
    bus.io_ddr_dout = 64'h5555_6666_7777_8888;
    #1 reset_n = 1'b0;
    #1 check_quiet("rst_async");
    prio_m = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    repeat (6) idle_check("rst_drop");

    // Tie after reset goes to port 0 again.
    do_burst(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 8'd2, '0, 1'b0, '0);
    clear_reqs();
    idle_check("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Two-port burst arbiter that shares the single MiSTer DDR3 Avalon-MM master port between two requesters inside `Main`: port 0 is the graphics/tile fetch path, and port 1 is the frame-buffer writer. It grants whole bursts in round-robin order. While a port is granted, its command and write data pass to `io_ddr_*`, and read beats are routed back only to the owning port. It sits between the requesters and the top-level `DDRAM_*` pins and runs in the fast system clock domain.

## Interface
- `ADDR_WIDTH`, default 32: byte address width on all ports.
- `DATA_WIDTH`, default 64: data beat width; the mask width is `DATA_WIDTH/8`.
- `BURST_WIDTH`, default 8: burst-count width.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_inK_rd`, K=0,1  in  1  read-burst request; held until accepted.
- `io_inK_wr`  in  1  write-beat valid; held for every beat of the burst.
- `io_inK_addr`  in  `ADDR_WIDTH`  burst start address; stable for the whole burst.
- `io_inK_burstLength`  in  `BURST_WIDTH`  beats in the burst.
- `io_inK_mask`  in  `DATA_WIDTH/8`  write byte enables.
- `io_inK_din`  in  `DATA_WIDTH`  write data.
- `io_inK_waitReq`  out  1  high = command or beat not accepted.
- `io_inK_valid`  out  1  read beat valid on `io_inK_dout`.
- `io_inK_dout`  out  `DATA_WIDTH`  read data; `io_ddr_dout` broadcast to both ports.
- `io_inK_burstDone`  out  1  one-cycle pulse on the last beat of the port's burst.
- `io_ddr_rd`, `io_ddr_wr`  out  1  DDR read request / write beat.
- `io_ddr_addr`  out  `ADDR_WIDTH`  DDR address.
- `io_ddr_burstLength`  out  `BURST_WIDTH`  DDR burst count.
- `io_ddr_mask`  out  `DATA_WIDTH/8`  DDR byte enables.
- `io_ddr_din`  out  `DATA_WIDTH`  DDR write data.
- `io_ddr_dout`  in  `DATA_WIDTH`  DDR read data.
- `io_ddr_waitReq`  in  1  DDR busy.
- `io_ddr_valid`  in  1  DDR read beat valid.

## Operation
- State machine states are `IDLE`, `READ_CMD`, `READ_DATA` and `WRITE`. Registers are `state`, `grant` (1 bit), `prio` (1 bit) and `beats` (`BURST_WIDTH`).
- In `IDLE`, a port is requesting when `rd|wr` is high.
  - If only one port requests, it wins.
  - If both request, port `prio` wins.
  - The winner is latched in `grant`, and `beats` is loaded with its `burstLength`.
  - The next state is `READ_CMD` if the winner's `rd` is high, otherwise `WRITE`. `rd` takes precedence when `rd` and `wr` are both high.
- In any state other than `IDLE`, `io_ddr_rd/wr/addr/burstLength/mask/din` are combinational copies of the granted port's inputs. In `IDLE` all of them are 0.
- `READ_CMD`:
  - `io_ddr_rd` = granted `rd`.
  - When `io_ddr_waitReq` is low, the command is accepted and the state goes to `READ_DATA`.
- `READ_DATA`:
  - `io_ddr_rd` = 0.
  - Each `io_ddr_valid` decrements `beats` and asserts the granted port's `valid`.
  - The beat with `beats==1` raises `burstDone` and returns the state to `IDLE`.
- `WRITE`:
  - `io_ddr_wr` = granted `wr`.
  - Each beat with `wr & ~io_ddr_waitReq` decrements `beats`.
  - The beat with `beats==1` raises `burstDone` and returns the state to `IDLE`.
- `prio` toggles to `~grant` on every burst completion.
- The granted port's `waitReq` = `io_ddr_waitReq` in `READ_CMD` and `WRITE`, and 1 otherwise. The ungranted port's `waitReq` is always 1.
- `valid` for both ports is 0 outside `READ_DATA`, including stray `io_ddr_valid`.
- A `burstLength` of 0 is treated as 2^`BURST_WIDTH` beats, because the counter wraps.

## Timing
- Reset values:
  - `state` = `IDLE`, `grant` = 0, `prio` = 0, `beats` = 0.
  - All `io_ddr_*` outputs = 0.
  - Both `waitReq` = 1.
  - Both `valid` and `burstDone` = 0.
- Arbitration latency: a request seen in `IDLE` at cycle n puts the command on `io_ddr_*` at cycle n+1.
- After a last beat at cycle m, the state is `IDLE` at m+1 and the earliest next command is at m+2. There is no back-to-back burst issue.
- Read data has zero added latency: `io_inK_valid` and `io_inK_dout` equal `io_ddr_valid` and `io_ddr_dout` in the same cycle.
- Asserting `reset_n` low mid-burst aborts immediately to `IDLE`. Outstanding DDR beats that arrive afterwards are dropped, because `valid` is 0 in `IDLE`.
- A request that drops while waiting in `IDLE` is simply not granted. Requests are not latched.

## Test plan
- Single read, port 0:
  - Stimulus: `rd` with addr 0x1000, burst 4; DDR waitReq high 2 cycles, then 4 valid beats.
  - Required: `io_ddr_rd` for 3 cycles; `io_in0_valid` ×4; `burstDone` on beat 4; `io_in1_valid` stays 0.
- Write, port 1:
  - Stimulus: burst 3, with DDR waitReq toggling 1,0,1,0,0.
  - Required: exactly 3 accepted beats; `io_in1_waitReq` mirrors DDR; return to `IDLE` the cycle after beat 3.
- Contention:
  - Stimulus: both ports request continuously from reset.
  - Required: grant order 0,1,0,1; each command starts 2 cycles after the previous last beat.
- Stray DDR beats:
  - Stimulus: `io_ddr_valid` pulses while in `IDLE` and `WRITE`.
  - Required: no `valid` or `burstDone` on either port.
- Reset mid-burst:
  - Stimulus: `reset_n` low during beat 2 of a burst-8 read.
  - Required: all outputs at reset values asynchronously; remaining beats ignored; next request granted normally.
- Zero burst length:
  - Stimulus: `burstLength` 0 write.
  - Required: 256 beats accepted before `burstDone`.
